// File: rtl/axi_id_remap_table.sv
// rtl/axi_id_remap_table.sv - wide-to-narrow AXI ID remap table with per-slot outstanding counters
// Lookup and allocation are combinational on registered state; counters update on the next edge.
module axi_id_remap_table #(
   parameter int ID_WIDTH_IN     = 8,
   parameter int ID_WIDTH_OUT    = 4,
   parameter int NUM_SLOTS       = 16,
   parameter int MAX_TXNS_PER_ID = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    incr_i,
   input  logic [ID_WIDTH_IN-1:0]  ID_i,
   output logic [ID_WIDTH_OUT-1:0] ID_o,
   output logic                    full_o,
   input  logic                    release_ID_i,
   input  logic [ID_WIDTH_OUT-1:0] BID_i,
   output logic [ID_WIDTH_IN-1:0]  BID_o,
   output logic                    empty_o
);

   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CW = $clog2(MAX_TXNS_PER_ID + 1);

   generate
      if (ID_WIDTH_OUT < SW) begin : g_bad_id_width
         $error("ID_WIDTH_OUT too narrow for NUM_SLOTS");
      end
      if (NUM_SLOTS < 2 || NUM_SLOTS > 256 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
         $error("NUM_SLOTS must be a power of two in 2..256");
      end
      if (MAX_TXNS_PER_ID < 1) begin : g_bad_max
         $error("MAX_TXNS_PER_ID must be at least 1");
      end
   endgenerate

   logic [CW-1:0]          cnt_q [NUM_SLOTS];
   logic [CW-1:0]          cnt_d [NUM_SLOTS];
   logic [ID_WIDTH_IN-1:0] id_q  [NUM_SLOTS];
   logic [ID_WIDTH_IN-1:0] id_d  [NUM_SLOTS];

   logic          hit;
   logic          free_found;
   logic [SW-1:0] hit_idx;
   logic [SW-1:0] free_idx;
   logic [SW-1:0] target;
   logic [SW-1:0] rel_idx;
   logic          full;
   logic          push;
   logic          rel_ok;
   logic          any_valid;
   logic          unused_bid;

   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      any_valid  = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (cnt_q[i] != '0) begin
            any_valid = 1'b1;
            if (id_q[i] == ID_i) begin
               hit     = 1'b1;
               hit_idx = SW'(i);
            end
         end
      end
      // Descending scan so the lowest free index is the one left standing.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (cnt_q[i] == '0) begin
            free_found = 1'b1;
            free_idx   = SW'(i);
         end
      end
      target  = hit ? hit_idx : free_idx;
      full    = hit ? (cnt_q[hit_idx] == CW'(MAX_TXNS_PER_ID)) : ~free_found;
      push    = incr_i & ~full;
      rel_idx = BID_i[SW-1:0];
      rel_ok  = release_ID_i & (cnt_q[rel_idx] != '0);

      for (int i = 0; i < NUM_SLOTS; i++) begin
         cnt_d[i] = cnt_q[i];
         id_d[i]  = id_q[i];
         if (push && (target == SW'(i)) && !(rel_ok && (rel_idx == SW'(i)))) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end else if (rel_ok && (rel_idx == SW'(i)) && !(push && (target == SW'(i)))) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
         end
         if (push && !hit && (target == SW'(i))) begin
            id_d[i] = ID_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_q[i] <= '0;
            id_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_q[i] <= cnt_d[i];
            id_q[i]  <= id_d[i];
         end
      end
   end

   assign ID_o       = ID_WIDTH_OUT'(target);
   assign full_o     = full;
   assign BID_o      = id_q[rel_idx];
   assign empty_o    = ~any_valid;
   assign unused_bid = ^BID_i;

endmodule

// File: tb/tb_axi_id_remap_table.sv
// tb/tb_axi_id_remap_table.sv - directed scoreboard bench for axi_id_remap_table
// Expected values are queued when a step is driven and popped when outputs are sampled.
module tb_axi_id_remap_table;

   logic       clk;
   logic       rst_n;
   logic       incr_i;
   logic [7:0] ID_i;
   logic [3:0] ID_o;
   logic       full_o;
   logic       release_ID_i;
   logic [3:0] BID_i;
   logic [7:0] BID_o;
   logic       empty_o;

   int n_pass;
   int n_total;
   logic [31:0] exp_q [$];

   axi_id_remap_table #(
      .ID_WIDTH_IN(8), .ID_WIDTH_OUT(4), .NUM_SLOTS(4), .MAX_TXNS_PER_ID(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .incr_i(incr_i), .ID_i(ID_i), .ID_o(ID_o),
      .full_o(full_o), .release_ID_i(release_ID_i), .BID_i(BID_i),
      .BID_o(BID_o), .empty_o(empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic exp_push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_total++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s scoreboard empty, observed %0h", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s observed %0h expected %0h", tag, obs, e);
   endtask

   task automatic expect3(input logic [3:0] id, input logic full, input logic empty);
      exp_push({28'd0, id});
      exp_push({31'd0, full});
      exp_push({31'd0, empty});
   endtask

   task automatic check3(input string tag);
      check({tag, ".id"}, {28'd0, ID_o});
      check({tag, ".full"}, {31'd0, full_o});
      check({tag, ".empty"}, {31'd0, empty_o});
   endtask

   task automatic drive(input logic inc, input logic [7:0] id, input logic rel, input logic [3:0] bid);
      incr_i       = inc;
      ID_i         = id;
      release_ID_i = rel;
      BID_i        = bid;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 4'h0);
      #12;
      expect3(4'd0, 1'b0, 1'b1); exp_push(32'h0);
      @(negedge clk);
      check3("reset"); check("reset.bid", {24'd0, BID_o});
      rst_n = 1'b1;
      adv();

      // Three distinct pushes land in slots 0,1,2.
      drive(1'b1, 8'hA5, 1'b0, 4'h0); expect3(4'd0, 1'b0, 1'b1);
      @(negedge clk); check3("push_a5"); adv();
      drive(1'b1, 8'h3C, 1'b0, 4'h0); expect3(4'd1, 1'b0, 1'b0);
      @(negedge clk); check3("push_3c"); adv();
      drive(1'b1, 8'h77, 1'b0, 4'h0); expect3(4'd2, 1'b0, 1'b0);
      @(negedge clk); check3("push_77"); adv();
      drive(1'b0, 8'h00, 1'b0, 4'h1); exp_push(32'h3C); exp_push(32'hA5);
      @(negedge clk); check("bid1", {24'd0, BID_o});
      BID_i = 4'h0; #1; check("bid0", {24'd0, BID_o});
      adv();

      // Second A5 reaches the limit; a third is refused without changing state.
      drive(1'b1, 8'hA5, 1'b0, 4'h0); expect3(4'd0, 1'b0, 1'b0);
      @(negedge clk); check3("a5_second"); adv();
      drive(1'b1, 8'hA5, 1'b0, 4'h0); exp_push(32'h1);
      @(negedge clk); check("a5_third.full", {31'd0, full_o}); adv();
      exp_push(32'h1);
      @(negedge clk); check("a5_still_full", {31'd0, full_o});
      adv();
      drive(1'b1, 8'h11, 1'b0, 4'h0); expect3(4'd3, 1'b0, 1'b0);
      @(negedge clk); check3("push_11"); adv();

      // Table full: same-cycle release is not visible, next cycle reuses slot 2.
      drive(1'b1, 8'h99, 1'b0, 4'h0); exp_push(32'h1);
      @(negedge clk); check("new_full", {31'd0, full_o}); adv();
      drive(1'b1, 8'h99, 1'b1, 4'h2); exp_push(32'h1);
      @(negedge clk); check("rel_same_cycle_full", {31'd0, full_o}); adv();
      drive(1'b1, 8'h99, 1'b0, 4'h0); expect3(4'd2, 1'b0, 1'b0);
      @(negedge clk); check3("reuse_slot2"); adv();

      // Push hit on slot 1 and release slot 3 (via upper-bit-set BID) together.
      drive(1'b1, 8'h3C, 1'b1, 4'hF); expect3(4'd1, 1'b0, 1'b0);
      @(negedge clk); check3("push_rel_diff"); adv();
      drive(1'b0, 8'h11, 1'b0, 4'h3); expect3(4'd3, 1'b0, 1'b0); exp_push(32'h11);
      @(negedge clk); check3("freed_slot3_miss"); check("retained_id", {24'd0, BID_o});
      drive(1'b1, 8'h3C, 1'b0, 4'h0); exp_push(32'h1);
      #1; check("slot1_at_max", {31'd0, full_o});
      drive(1'b0, 8'h00, 1'b0, 4'h0);
      adv();

      // Net-zero push/release on the same slot.
      rst_n = 1'b0; #2; rst_n = 1'b1; adv();
      drive(1'b1, 8'hA5, 1'b0, 4'h0); adv();
      drive(1'b1, 8'hA5, 1'b1, 4'h0); expect3(4'd0, 1'b0, 1'b0);
      @(negedge clk); check3("same_slot_net0"); adv();
      drive(1'b1, 8'hA5, 1'b0, 4'h0); expect3(4'd0, 1'b0, 1'b0);
      @(negedge clk); check3("cnt_still_1");
      incr_i = 1'b0; release_ID_i = 1'b1; BID_i = 4'h0; adv();
      drive(1'b0, 8'h00, 1'b0, 4'h0); exp_push(32'h1);
      @(negedge clk); check("drained_empty", {31'd0, empty_o}); adv();

      // Release on an empty slot must not underflow.
      drive(1'b0, 8'h00, 1'b1, 4'h3); adv();
      drive(1'b1, 8'h42, 1'b0, 4'h0); expect3(4'd0, 1'b0, 1'b1);
      @(negedge clk); check3("no_underflow"); adv();

      // Asynchronous reset mid-cycle with three slots live.
      drive(1'b1, 8'h43, 1'b0, 4'h0); adv();
      drive(1'b1, 8'h44, 1'b0, 4'h0); adv();
      drive(1'b0, 8'h44, 1'b0, 4'h1); expect3(4'd2, 1'b0, 1'b0);
      @(negedge clk); check3("three_live");
      #2; rst_n = 1'b0; #1;
      expect3(4'd0, 1'b0, 1'b1); exp_push(32'h0);
      check3("async_reset"); check("async_reset.bid", {24'd0, BID_o});
      adv(); rst_n = 1'b1; adv();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_id_remap_table.md
AXI_ID_REMAP_TABLE -- requirements
Module: axi_id_remap_table

Interface
REQ-001 SHALL have parameter ID_WIDTH_IN, default 8, width of upstream (wide) AXI ID.
REQ-002 SHALL have parameter ID_WIDTH_OUT, default 4, width of remapped (narrow) ID; elaboration error if < $clog2(NUM_SLOTS).
REQ-003 SHALL have parameter NUM_SLOTS, default 16, table depth, power of two, 2..256.
REQ-004 SHALL have parameter MAX_TXNS_PER_ID, default 8, max outstanding transactions per slot, >= 1.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port incr_i  input  1  allocate/reuse request for ID_i this cycle.
REQ-008 SHALL have port ID_i  input  ID_WIDTH_IN  upstream ID to map.
REQ-009 SHALL have port ID_o  output  ID_WIDTH_OUT  remapped ID for ID_i, zero-extended slot index.
REQ-010 SHALL have port full_o  output  1  ID_i cannot be accepted this cycle.
REQ-011 SHALL have port release_ID_i  input  1  one transaction on slot BID_i completed.
REQ-012 SHALL have port BID_i  input  ID_WIDTH_OUT  remapped ID being released/looked up.
REQ-013 SHALL have port BID_o  output  ID_WIDTH_IN  original ID stored in slot BID_i.
REQ-014 SHALL have port empty_o  output  1  no slot has outstanding transactions.

Function
REQ-015 Each slot SHALL hold: valid bit, stored ID (ID_WIDTH_IN), counter 0..MAX_TXNS_PER_ID; valid == (counter != 0).
REQ-016 Match: combinational; hit if some valid slot stores ID_i (at most one can); hit slot is the target.
REQ-017 Miss: target SHALL be the lowest-index invalid slot (priority encoder, index 0 highest priority).
REQ-018 ID_o SHALL equal target index, combinational from current registered state (same-cycle release not visible).
REQ-019 full_o SHALL be 1 when (hit and counter == MAX_TXNS_PER_ID) or (miss and no invalid slot); ID_o don't-care then.
REQ-020 Accepted push (incr_i & ~full_o): hit -> counter+1; miss -> slot valid, ID stored, counter=1; effect next edge.
REQ-021 incr_i while full_o SHALL be ignored, no state change.
REQ-022 Release (release_ID_i) SHALL decrement counter of slot BID_i[$clog2(NUM_SLOTS)-1:0]; slot invalid when counter reaches 0; stored ID retained.
REQ-023 Release on a slot with counter 0 SHALL be ignored (no underflow).
REQ-024 Push and release on same slot in one cycle SHALL leave counter unchanged (net 0); slot stays valid.
REQ-025 Push and release on different slots in one cycle SHALL both take effect.
REQ-026 A slot freed this cycle SHALL NOT be allocatable until next cycle (REQ-018).
REQ-027 BID_o SHALL be combinational read of stored ID at BID_i, independent of valid.
REQ-028 empty_o SHALL be combinational NOR of all valid bits.
REQ-029 Upper BID_i bits above $clog2(NUM_SLOTS) SHALL be ignored.

Reset
REQ-030 rst_n low SHALL clear asynchronously all valid bits, counters and stored IDs to 0.
REQ-031 After reset: empty_o=1, full_o=0, ID_o=0, BID_o=0; reset mid-operation discards all outstanding mappings.

Verification (NUM_SLOTS=4, MAX_TXNS_PER_ID=2, ID_WIDTH_IN=8, ID_WIDTH_OUT=4)
REQ-032 Reset, push 0xA5, 0x3C, 0x77 -> ID_o 0,1,2; then BID_i=1 gives BID_o=0x3C; empty_o 1->0 after first push.
REQ-033 Push 0xA5 twice -> both ID_o=0, slot0 counter 2; third 0xA5 push -> full_o=1, ignored; other IDs still accepted.
REQ-034 Fill 4 distinct IDs -> full_o=1 for new ID; release BID_i=2 -> next cycle new ID gets ID_o=2, full_o=0.
REQ-035 Slot0 counter 1; same cycle push 0xA5 and release BID_i=0 -> counter stays 1, valid; next release -> empty_o=1.
REQ-036 Release BID_i=3 on empty table -> no change, empty_o stays 1; assert rst_n low with 3 slots valid -> immediate empty_o=1, full_o=0.
